// File: rtl/seat_pkg.sv
// Shared constants, state/status encodings and seat-index helper for the seat RAM sequencer.
package seat_pkg;
  localparam int unsigned NUM_SEATS = 32;
  localparam int unsigned SEAT_W    = $clog2(NUM_SEATS);
  localparam int unsigned STU_W     = 32;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} seat_state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_FULL = 2'b01, ST_NOT_OCC = 2'b10} seat_status_t;

  function automatic logic [SEAT_W-1:0] seat_inc(input logic [SEAT_W-1:0] s);
    return (s == SEAT_W'(NUM_SEATS - 1)) ? '0 : s + SEAT_W'(1);
  endfunction
endpackage

// File: rtl/seat_assign_ctrl_if.sv
// Request/response handshake between enrolment logic (master) and the seat controller (slave).
interface seat_assign_ctrl_if;
  import seat_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_release;
  logic [STU_W-1:0]    req_student_no;
  logic [SEAT_W-1:0]   req_seat_no;
  logic                resp_valid;
  logic                resp_ready;
  logic [SEAT_W-1:0]   resp_seat_no;
  seat_status_t        resp_status;

  modport master (
    output req_valid, req_release, req_student_no, req_seat_no, resp_ready,
    input  req_ready, resp_valid, resp_seat_no, resp_status
  );

  modport slave (
    input  req_valid, req_release, req_student_no, req_seat_no, resp_ready,
    output req_ready, resp_valid, resp_seat_no, resp_status
  );
endinterface

// File: rtl/seat_occupancy.sv
// Seat occupancy bitmap with occupied-seat counter; the bitmap is the sole authority on free seats.
module seat_occupancy
  import seat_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic              clr_en,
  input  logic [SEAT_W-1:0] upd_idx,
  input  logic [SEAT_W-1:0] test_idx,
  output logic              test_occ,
  output logic [SEAT_W:0]   seat_count,
  output logic              seats_full
);
  logic [NUM_SEATS-1:0] occ_q, occ_d;
  logic [SEAT_W:0]      count_q, count_d;

  // Guarding on the current bit keeps the count within 0..NUM_SEATS.
  always_comb begin
    occ_d   = occ_q;
    count_d = count_q;
    if (set_en && !occ_q[upd_idx]) begin
      occ_d[upd_idx] = 1'b1;
      count_d        = count_q + (SEAT_W+1)'(1);
    end else if (clr_en && occ_q[upd_idx]) begin
      occ_d[upd_idx] = 1'b0;
      count_d        = count_q - (SEAT_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      count_q <= count_d;
    end
  end

  assign test_occ   = occ_q[test_idx];
  assign seat_count = count_q;
  assign seats_full = (count_q == (SEAT_W+1)'(NUM_SEATS));
endmodule

// File: rtl/seat_assign_ctrl.sv
// Seat RAM sequencer: allocates seats round-robin, releases seats, drives the RAM write port.
module seat_assign_ctrl
  import seat_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  seat_assign_ctrl_if.slave   bus,
  output logic                write_mem1,
  output logic [STU_W-1:0]    Student_No_mem1,
  output logic [SEAT_W-1:0]   Seat_No_mem1,
  output logic [SEAT_W:0]     seat_count,
  output logic                seats_full
);
  seat_state_t       state_q, state_d;
  seat_status_t      status_q, status_d;
  logic [SEAT_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [SEAT_W-1:0] next_ptr_q, next_ptr_d;
  logic [SEAT_W-1:0] seat_q, seat_d;
  logic [STU_W-1:0]  stu_q, stu_d;
  logic              rel_q, rel_d;
  logic              resp_valid_q, resp_valid_d;
  logic              wr_q, wr_d;
  logic [STU_W-1:0]  wdata_q, wdata_d;
  logic [SEAT_W-1:0] waddr_q, waddr_d;
  logic              set_en, clr_en, test_occ;
  logic [SEAT_W-1:0] test_idx;

  assign test_idx = (state_q == SCAN) ? scan_ptr_q : seat_q;

  seat_occupancy u_occ (
    .clk        (clk),
    .reset      (reset),
    .set_en     (set_en),
    .clr_en     (clr_en),
    .upd_idx    (seat_q),
    .test_idx   (test_idx),
    .test_occ   (test_occ),
    .seat_count (seat_count),
    .seats_full (seats_full)
  );

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    scan_ptr_d   = scan_ptr_q;
    next_ptr_d   = next_ptr_q;
    seat_d       = seat_q;
    stu_d        = stu_q;
    rel_d        = rel_q;
    resp_valid_d = 1'b0;
    wr_d         = 1'b0;
    wdata_d      = '0;
    waddr_d      = '0;
    set_en       = 1'b0;
    clr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rel_d = bus.req_release;
          stu_d = bus.req_student_no;
          if (bus.req_release) begin
            seat_d  = bus.req_seat_no;
            state_d = WRITE;
          end else if (seats_full) begin
            seat_d   = '0;
            status_d = ST_FULL;
            state_d  = RESP;
          end else begin
            scan_ptr_d = next_ptr_q;
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        if (!test_occ) begin
          seat_d  = scan_ptr_q;
          state_d = WRITE;
        end else begin
          scan_ptr_d = seat_inc(scan_ptr_q);
        end
      end
      WRITE: begin
        state_d  = RESP;
        status_d = ST_OK;
        if (!rel_q) begin
          wr_d       = 1'b1;
          wdata_d    = stu_q;
          waddr_d    = seat_q;
          set_en     = 1'b1;
          next_ptr_d = seat_inc(seat_q);
        end else if (test_occ) begin
          wr_d    = 1'b1;
          waddr_d = seat_q;
          clr_en  = 1'b1;
        end else begin
          status_d = ST_NOT_OCC;
        end
      end
      RESP: begin
        // resp_valid is registered, so it rises one cycle after entering RESP.
        resp_valid_d = 1'b1;
        if (resp_valid_q && bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      status_q     <= ST_OK;
      scan_ptr_q   <= '0;
      next_ptr_q   <= '0;
      seat_q       <= '0;
      stu_q        <= '0;
      rel_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      scan_ptr_q   <= scan_ptr_d;
      next_ptr_q   <= next_ptr_d;
      seat_q       <= seat_d;
      stu_q        <= stu_d;
      rel_q        <= rel_d;
      resp_valid_q <= resp_valid_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_seat_no = seat_q;
  assign bus.resp_status  = status_q;
  assign write_mem1       = wr_q;
  assign Student_No_mem1  = wdata_q;
  assign Seat_No_mem1     = waddr_q;
endmodule

// File: tb/tb_seat_assign_ctrl.sv
// Scoreboard bench for seat_assign_ctrl: expected responses and RAM writes are queued, a monitor checks them.
module tb_seat_assign_ctrl;
  import seat_pkg::*;

  typedef struct packed {logic [4:0] seat; logic [1:0] status;} resp_t;
  typedef struct packed {logic [4:0] addr; logic [31:0] data;} wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_mem1;
  logic [31:0] Student_No_mem1;
  logic [4:0]  Seat_No_mem1;
  logic [5:0]  seat_count;
  logic        seats_full;

  resp_t exp_resp[$];
  wr_t   exp_wr[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  seat_assign_ctrl_if bus();

  seat_assign_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .write_mem1      (write_mem1),
    .Student_No_mem1 (Student_No_mem1),
    .Seat_No_mem1    (Seat_No_mem1),
    .seat_count      (seat_count),
    .seats_full      (seats_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every response handshake and every RAM write against the queues.
  always @(negedge clk) begin
    resp_t r;
    wr_t   w;
    if (bus.resp_valid && bus.resp_ready) begin
      if (exp_resp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL resp_unexpected: got seat %0d status %0d expected none", bus.resp_seat_no, bus.resp_status);
      end else begin
        r = exp_resp.pop_front();
        check("resp_seat", 64'(bus.resp_seat_no), 64'(r.seat));
        check("resp_status", 64'(bus.resp_status), 64'(r.status));
      end
    end
    if (write_mem1) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL write_unexpected: got addr %0d data %0d expected none", Seat_No_mem1, Student_No_mem1);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", 64'(Seat_No_mem1), 64'(w.addr));
        check("wr_data", 64'(Student_No_mem1), 64'(w.data));
      end
    end else if (Student_No_mem1 != 0 || Seat_No_mem1 != 0) begin
      n_checks++; n_fail++;
      $display("FAIL wr_idle_zero: got addr %0d data %0d expected 0 0", Seat_No_mem1, Student_No_mem1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_req(input logic rel, input logic [31:0] stu, input logic [4:0] seat);
    bit ok = 0;
    @(negedge clk);
    bus.req_valid      = 1'b1;
    bus.req_release    = rel;
    bus.req_student_no = stu;
    bus.req_seat_no    = seat;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    else begin
      n_checks++; n_fail++;
      $display("FAIL req_accept_timeout: got no req_ready expected accept");
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && (exp_resp.size() != 0 || exp_wr.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_resp.size() != 0 || exp_wr.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL outstanding_timeout: got %0d resp %0d writes pending expected 0", exp_resp.size(), exp_wr.size());
      exp_resp.delete();
      exp_wr.delete();
    end
  endtask

  task automatic alloc(input logic [31:0] stu, input logic [4:0] seat);
    exp_wr.push_back('{addr: seat, data: stu});
    exp_resp.push_back('{seat: seat, status: ST_OK});
    do_req(1'b0, stu, 5'd0);
    wait_done();
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_release = 1'b0;
    bus.req_student_no = '0; bus.req_seat_no = '0;
    bus.resp_ready = 1'b1;

    do_reset();
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_write", 64'(write_mem1), 64'd0);
    check("rst_count", 64'(seat_count), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);

    // First allocate with latency checks: write at k+2, resp_valid at k+3.
    exp_wr.push_back('{addr: 5'd0, data: 32'd1001});
    exp_resp.push_back('{seat: 5'd0, status: ST_OK});
    do_req(1'b0, 32'd1001, 5'd0);
    @(negedge clk); check("lat_wr_k0", 64'(write_mem1), 64'd0);
    @(negedge clk); check("lat_wr_k1", 64'(write_mem1), 64'd0);
    @(negedge clk); check("lat_wr_k2", 64'(write_mem1), 64'd1);
    check("lat_rv_k2", 64'(bus.resp_valid), 64'd0);
    @(negedge clk); check("lat_rv_k3", 64'(bus.resp_valid), 64'd1);
    wait_done();
    alloc(32'd1002, 5'd1);
    alloc(32'd1003, 5'd2);
    check("count_3", 64'(seat_count), 64'd3);

    for (int i = 3; i < 32; i++) alloc(32'(3000 + i), 5'(i));
    check("count_32", 64'(seat_count), 64'd32);
    check("full_32", 64'(seats_full), 64'd1);

    exp_resp.push_back('{seat: 5'd0, status: ST_FULL});
    do_req(1'b0, 32'd9999, 5'd0);
    wait_done();
    check("full_count", 64'(seat_count), 64'd32);
    check("full_flag", 64'(seats_full), 64'd1);

    exp_wr.push_back('{addr: 5'd5, data: 32'd0});
    exp_resp.push_back('{seat: 5'd5, status: ST_OK});
    do_req(1'b1, 32'd0, 5'd5);
    wait_done();
    check("rel_count", 64'(seat_count), 64'd31);
    check("rel_full", 64'(seats_full), 64'd0);
    alloc(32'd2000, 5'd5);
    check("wrap_count", 64'(seat_count), 64'd32);

    // Release of an unoccupied seat, response held while resp_ready is low.
    do_reset();
    bus.resp_ready = 1'b0;
    exp_resp.push_back('{seat: 5'd7, status: ST_NOT_OCC});
    do_req(1'b1, 32'd0, 5'd7);
    for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.resp_valid), 64'd1);
      check("hold_seat", 64'(bus.resp_seat_no), 64'd7);
      check("hold_status", 64'(bus.resp_status), 64'(ST_NOT_OCC));
    end
    bus.resp_ready = 1'b1;
    wait_done();
    check("notocc_count", 64'(seat_count), 64'd0);

    // Reset while the controller is scanning.
    alloc(32'd4000, 5'd0);
    alloc(32'd4001, 5'd1);
    alloc(32'd4002, 5'd2);
    do_req(1'b0, 32'd5555, 5'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("abort_count", 64'(seat_count), 64'd0);
    check("abort_req_ready", 64'(bus.req_ready), 64'd1);
    alloc(32'd6000, 5'd0);
    check("abort_after_count", 64'(seat_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
